// File: rtl/demux_1x4_32b_reg_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer: channel codes, defaults, select decode.
// Counter defaults exist only when DEMUX_CNT_EN is defined.
package demux_1x4_32b_reg_pkg;

    localparam int NUM_CH    = 4;
    localparam int DEF_WIDTH = 32;
`ifdef DEMUX_CNT_EN
    localparam int DEF_CNT_W = 8;
`endif

    typedef enum logic [1:0] {
        CH_A = 2'b00,
        CH_B = 2'b01,
        CH_C = 2'b10,
        CH_D = 2'b11
    } chSel_t;

    function automatic logic [NUM_CH-1:0] chOneHot(input logic [1:0] sel);
        logic [NUM_CH-1:0] oneHot;
        oneHot      = '0;
        oneHot[sel] = 1'b1;
        return oneHot;
    endfunction

endpackage

// File: rtl/demux_1x4_32b_reg_slot.sv
// One-entry output register slice with its own valid/ready handshake.
// With DEMUX_CNT_EN defined it also counts drain handshakes (wrapping, clearable).
module demux_slot
    import demux_1x4_32b_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
`ifdef DEMUX_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic drain;
    assign drain = out_valid & out_ready;

    // NOTE: state registers use non-blocking assignments so every slot samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (load) begin
            // A load wins over a same-edge drain: the new word replaces the old one.
            out_valid <= 1'b1;
            data_out  <= data_in;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_1x4_32b_reg.sv
// Registered 1-to-4 demultiplexer: one valid/ready input routed into four one-entry output slots.
// Optional per-channel drain counters are enabled by defining DEMUX_CNT_EN.
module demux_1x4_32b_reg
    import demux_1x4_32b_reg_pkg::*;
#(
`ifdef DEMUX_CNT_EN
    parameter int CNT_W = DEF_CNT_W,
`endif
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [WIDTH-1:0]  out_c,
    output logic [WIDTH-1:0]  out_d
`ifdef DEMUX_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic [CNT_W-1:0]  cnt_c,
    output logic [CNT_W-1:0]  cnt_d
`endif
);

    logic [NUM_CH-1:0] loadVec;
    logic [WIDTH-1:0]  slotData [NUM_CH];
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  slotCnt  [NUM_CH];
`endif

    // Only the addressed slot can stall the producer.
    assign in_ready = ~rst & (~out_valid[in_sel] | out_ready[in_sel]);
    assign loadVec  = (in_valid & in_ready) ? chOneHot(in_sel) : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : gSlot
        demux_slot #(
            .WIDTH(WIDTH)
`ifdef DEMUX_CNT_EN
            , .CNT_W(CNT_W)
`endif
        ) uSlot (
            .clk      (clk),
            .rst      (rst),
            .load     (loadVec[g]),
            .data_in  (in_data),
            .out_ready(out_ready[g]),
            .out_valid(out_valid[g]),
            .data_out (slotData[g])
`ifdef DEMUX_CNT_EN
            ,
            .cnt_clr  (cnt_clr),
            .cnt      (slotCnt[g])
`endif
        );
    end

    assign out_a = slotData[CH_A];
    assign out_b = slotData[CH_B];
    assign out_c = slotData[CH_C];
    assign out_d = slotData[CH_D];

`ifdef DEMUX_CNT_EN
    assign cnt_a = slotCnt[CH_A];
    assign cnt_b = slotCnt[CH_B];
    assign cnt_c = slotCnt[CH_C];
    assign cnt_d = slotCnt[CH_D];
`endif

endmodule
